// File: rtl/reminder_pkg.sv
// Shared types and helpers for the water-reminder scheduler.
//   sched_state_e : scheduler states (IDLE=0, COUNT=1, ALERT=2, SNOOZE=3)
//   bcd_t         : one BCD digit
//   bcd_valid2()  : true when both nibbles of a 2-digit BCD byte are 0..9
//   BCD_ZERO_MMSS : 00:00 in {min_t,min_u,sec_t,sec_u} packing
package reminder_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COUNT  = 2'd1,
    ALERT  = 2'd2,
    SNOOZE = 2'd3
  } sched_state_e;

  typedef logic [3:0] bcd_t;

  localparam logic [15:0] BCD_ZERO_MMSS = 16'h0000;

  function automatic logic bcd_valid2(input logic [7:0] v);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
  endfunction

endpackage

// File: rtl/reminder_scheduler_bcd_digit_down.sv
// One BCD digit down-counter, chained through borrow to build MM:SS.
// Ports:
//   clk, reset : clock, asynchronous active-high reset (value <= RST_VAL)
//   load       : load load_val (has priority over dec)
//   load_val   : digit to load
//   dec        : decrement request; wraps 0 -> MAX
//   value      : current digit
//   borrow     : dec requested while digit is 0 (decrement the next digit)
module bcd_digit_down
  import reminder_pkg::*;
#(
  parameter bcd_t MAX     = 4'd9,
  parameter bcd_t RST_VAL = 4'd0
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  bcd_t load_val,
  input  logic dec,
  output bcd_t value,
  output logic borrow
);

  // Digit register: load, else decrement with wrap to MAX, else hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value <= RST_VAL;
    end else if (load) begin
      value <= load_val;
    end else if (dec) begin
      value <= (value == 4'd0) ? MAX : (value - 4'd1);
    end else begin
      value <= value;
    end
  end

  assign borrow = dec && (value == 4'd0);

endmodule

// File: rtl/reminder_scheduler.sv
// Water-reminder sequencer: counts a BCD MM:SS interval down on a 1 Hz tick,
// raises an alert at 00:00, waits for ack, logs missed reminders, re-arms.
// Optional feature macro: REMINDER_SNOOZE_EN (snooze from ALERT into SNOOZE).
// Ports:
//   clk, reset   : clock, asynchronous active-high reset
//   tick_1hz     : one-clk pulse per second
//   enable       : level, 0 pauses (forces IDLE, time held)
//   interval_bcd : MM interval in BCD, sampled on load
//   load, ack, snooze : one-clk command pulses
//   remain_bcd   : {min_t,min_u,sec_t,sec_u} remaining time
//   alert        : high while in ALERT
//   chime        : one-clk pulse on each entry into ALERT
//   state        : current state encoding
//   missed       : saturating count of timed-out reminders
module reminder_scheduler
  import reminder_pkg::*;
#(
  parameter logic [7:0] DEFAULT_MIN     = 8'h30,
  parameter int         ALERT_TIMEOUT_S = 60,
  parameter logic [7:0] SNOOZE_MIN      = 8'h05,
  parameter int         MISS_W          = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick_1hz,
  input  logic              enable,
  input  logic [7:0]        interval_bcd,
  input  logic              load,
  input  logic              ack,
  input  logic              snooze,
  output logic [15:0]       remain_bcd,
  output logic              alert,
  output logic              chime,
  output logic [1:0]        state,
  output logic [MISS_W-1:0] missed
);

  localparam logic [7:0]        TIMEOUT_LAST = 8'(ALERT_TIMEOUT_S - 1);
  localparam logic [MISS_W-1:0] MISS_MAX     = {MISS_W{1'b1}};
  localparam logic [MISS_W-1:0] MISS_ONE     = {{(MISS_W-1){1'b0}}, 1'b1};

  sched_state_e      cur_state, nxt_state;
  logic [7:0]        interval_q, interval_d;
  logic [7:0]        alert_cnt, alert_cnt_d;
  logic [MISS_W-1:0] missed_d;
  logic              alert_d, chime_d;
  logic              dig_load, dig_dec;
  logic [15:0]       dig_val;
  logic              snooze_req;
  bcd_t              sec_u, sec_t, min_u, min_t;
  logic              su_borrow, st_borrow, mu_borrow, mt_borrow_unused;

`ifdef REMINDER_SNOOZE_EN
  assign snooze_req = snooze;
`else
  logic snooze_unused;
  assign snooze_req    = 1'b0;
  assign snooze_unused = snooze;
`endif

  assign remain_bcd = {min_t, min_u, sec_t, sec_u};
  assign state      = cur_state;

  // Next-state, command priority and datapath control.
  always_comb begin
    nxt_state   = cur_state;
    interval_d  = interval_q;
    alert_cnt_d = alert_cnt;
    missed_d    = missed;
    chime_d     = 1'b0;
    dig_load    = 1'b0;
    dig_dec     = 1'b0;
    dig_val     = {interval_q, 8'h00};
    if (load) begin
      // Invalid or zero interval falls back to the default.
      if (bcd_valid2(interval_bcd) && (interval_bcd != 8'h00)) begin
        interval_d = interval_bcd;
      end else begin
        interval_d = DEFAULT_MIN;
      end
      dig_load    = 1'b1;
      dig_val     = {interval_d, 8'h00};
      alert_cnt_d = 8'd0;
      nxt_state   = enable ? COUNT : IDLE;
    end else if (!enable) begin
      nxt_state   = IDLE;
      alert_cnt_d = 8'd0;
    end else begin
      case (cur_state)
        IDLE: begin
          nxt_state = COUNT;
          // An expired countdown resumes from a fresh interval.
          if (remain_bcd == BCD_ZERO_MMSS) begin
            dig_load = 1'b1;
          end else begin
            dig_load = 1'b0;
          end
        end
        COUNT, SNOOZE: begin
          if (tick_1hz) begin
            dig_dec = 1'b1;
            if (remain_bcd == 16'h0001) begin
              nxt_state = ALERT;
              chime_d   = 1'b1;
            end else begin
              nxt_state = cur_state;
            end
          end else begin
            dig_dec = 1'b0;
          end
        end
        ALERT: begin
          if (ack) begin
            nxt_state   = COUNT;
            dig_load    = 1'b1;
            alert_cnt_d = 8'd0;
          end else if (snooze_req) begin
            nxt_state   = SNOOZE;
            dig_load    = 1'b1;
            dig_val     = {SNOOZE_MIN, 8'h00};
            alert_cnt_d = 8'd0;
          end else if (tick_1hz) begin
            if (alert_cnt == TIMEOUT_LAST) begin
              missed_d    = (missed == MISS_MAX) ? missed : (missed + MISS_ONE);
              nxt_state   = COUNT;
              dig_load    = 1'b1;
              alert_cnt_d = 8'd0;
            end else begin
              alert_cnt_d = alert_cnt + 8'd1;
            end
          end else begin
            alert_cnt_d = alert_cnt;
          end
        end
        default: begin
          nxt_state = IDLE;
        end
      endcase
    end
    alert_d = (nxt_state == ALERT);
  end

  // Control and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_state  <= IDLE;
      interval_q <= DEFAULT_MIN;
      alert_cnt  <= 8'd0;
      missed     <= {MISS_W{1'b0}};
      alert      <= 1'b0;
      chime      <= 1'b0;
    end else begin
      cur_state  <= nxt_state;
      interval_q <= interval_d;
      alert_cnt  <= alert_cnt_d;
      missed     <= missed_d;
      alert      <= alert_d;
      chime      <= chime_d;
    end
  end

  bcd_digit_down #(.MAX(4'd9), .RST_VAL(4'd0)) u_sec_u (
    .clk(clk), .reset(reset), .load(dig_load), .load_val(dig_val[3:0]),
    .dec(dig_dec), .value(sec_u), .borrow(su_borrow)
  );
  bcd_digit_down #(.MAX(4'd5), .RST_VAL(4'd0)) u_sec_t (
    .clk(clk), .reset(reset), .load(dig_load), .load_val(dig_val[7:4]),
    .dec(su_borrow), .value(sec_t), .borrow(st_borrow)
  );
  bcd_digit_down #(.MAX(4'd9), .RST_VAL(DEFAULT_MIN[3:0])) u_min_u (
    .clk(clk), .reset(reset), .load(dig_load), .load_val(dig_val[11:8]),
    .dec(st_borrow), .value(min_u), .borrow(mu_borrow)
  );
  // The top digit never borrows: 00:01 -> 00:00 ends the countdown.
  bcd_digit_down #(.MAX(4'd9), .RST_VAL(DEFAULT_MIN[7:4])) u_min_t (
    .clk(clk), .reset(reset), .load(dig_load), .load_val(dig_val[15:12]),
    .dec(mu_borrow), .value(min_t), .borrow(mt_borrow_unused)
  );

endmodule

// File: tb/tb_reminder_scheduler.sv
// Self-checking bench for reminder_scheduler: a load-vector table, directed
// multi-cycle sequences and a randomized phase, all checked every clock
// against a seconds-based reference model.
module tb_reminder_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        tick_1hz, enable, load, ack, snooze;
  logic [7:0]  interval_bcd;
  logic [15:0] remain_bcd;
  logic        alert, chime;
  logic [1:0]  state;
  logic [3:0]  missed;

  int total = 0;
  int bad   = 0;

`ifdef REMINDER_SNOOZE_EN
  localparam bit SNOOZE_ON = 1'b1;
`else
  localparam bit SNOOZE_ON = 1'b0;
`endif

  reminder_scheduler dut (
    .clk(clk), .reset(reset), .tick_1hz(tick_1hz), .enable(enable),
    .interval_bcd(interval_bcd), .load(load), .ack(ack), .snooze(snooze),
    .remain_bcd(remain_bcd), .alert(alert), .chime(chime), .state(state),
    .missed(missed)
  );

  always #5 clk = ~clk;

  // Reference model: time kept as plain seconds, interval as binary minutes.
  int m_state, m_interval, m_remain, m_missed, m_cnt;
  bit m_chime;

  function automatic logic [15:0] to_bcd(input int secs);
    int mm, ss;
    mm = secs / 60;
    ss = secs % 60;
    return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
  endfunction

  task automatic model_reset();
    m_state = 0; m_interval = 30; m_remain = 30 * 60; m_missed = 0; m_cnt = 0; m_chime = 0;
  endtask

  task automatic model_step(input bit ld, input logic [7:0] lv, input bit en,
                            input bit ak, input bit sz, input bit tk);
    int hi, lo;
    m_chime = 0;
    if (ld) begin
      hi = int'(lv[7:4]);
      lo = int'(lv[3:0]);
      if (hi <= 9 && lo <= 9 && (hi + lo) != 0) m_interval = hi * 10 + lo;
      else m_interval = 30;
      m_remain = m_interval * 60;
      m_cnt = 0;
      m_state = en ? 1 : 0;
    end else if (!en) begin
      m_state = 0;
      m_cnt = 0;
    end else if (m_state == 0) begin
      if (m_remain == 0) m_remain = m_interval * 60;
      m_state = 1;
    end else if (m_state == 1 || m_state == 3) begin
      if (tk) begin
        m_remain = m_remain - 1;
        if (m_remain == 0) begin m_state = 2; m_chime = 1; end
      end
    end else begin
      if (ak) begin
        m_remain = m_interval * 60; m_state = 1; m_cnt = 0;
      end else if (sz && SNOOZE_ON) begin
        m_remain = 5 * 60; m_state = 3; m_cnt = 0;
      end else if (tk) begin
        m_cnt = m_cnt + 1;
        if (m_cnt == 60) begin
          if (m_missed < 15) m_missed = m_missed + 1;
          m_remain = m_interval * 60; m_state = 1; m_cnt = 0;
        end
      end
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("model_remain", int'(remain_bcd), int'(to_bcd(m_remain)));
    chk("model_state", int'(state), m_state);
    chk("model_alert", int'(alert), (m_state == 2) ? 1 : 0);
    chk("model_chime", int'(chime), int'(m_chime));
    chk("model_missed", int'(missed), m_missed);
  endtask

  // One clock: drive inputs, update model at the edge, check 1 time unit later.
  task automatic cyc(input bit ld, input logic [7:0] lv, input bit en,
                     input bit ak, input bit sz, input bit tk);
    load = ld; interval_bcd = lv; enable = en; ack = ak; snooze = sz; tick_1hz = tk;
    @(posedge clk);
    model_step(ld, lv, en, ak, sz, tk);
    #1;
    check_model();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
  endtask

  typedef struct {
    logic [7:0]  lv;
    bit          en;
    logic [15:0] exp_remain;
    logic [1:0]  exp_state;
  } vec_t;

  vec_t vecs[8];
  bit   en_r;

  initial begin
    vecs[0] = '{8'h01, 1'b1, 16'h0100, 2'd1};
    vecs[1] = '{8'h1A, 1'b1, 16'h3000, 2'd1};
    vecs[2] = '{8'h00, 1'b1, 16'h3000, 2'd1};
    vecs[3] = '{8'h99, 1'b1, 16'h9900, 2'd1};
    vecs[4] = '{8'hA5, 1'b1, 16'h3000, 2'd1};
    vecs[5] = '{8'h45, 1'b1, 16'h4500, 2'd1};
    vecs[6] = '{8'h12, 1'b0, 16'h1200, 2'd0};
    vecs[7] = '{8'h09, 1'b1, 16'h0900, 2'd1};

    reset = 1'b1; load = 1'b0; interval_bcd = 8'h00; enable = 1'b0;
    ack = 1'b0; snooze = 1'b0; tick_1hz = 1'b0;
    model_reset();
    #8;
    chk("reset_remain", int'(remain_bcd), 16'h3000);
    chk("reset_state", int'(state), 0);
    chk("reset_alert", int'(alert), 0);
    chk("reset_chime", int'(chime), 0);
    chk("reset_missed", int'(missed), 0);
    reset = 1'b0;

    // Load table: valid, invalid-digit and zero intervals, enable on/off.
    foreach (vecs[i]) begin
      cyc(1'b1, vecs[i].lv, vecs[i].en, 1'b0, 1'b0, 1'b0);
      chk("tbl_remain", int'(remain_bcd), int'(vecs[i].exp_remain));
      chk("tbl_state", int'(state), int'(vecs[i].exp_state));
      chk("tbl_alert", int'(alert), 0);
    end

    // 01:00 counts down to ALERT with a single chime.
    cyc(1'b1, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("t1_first_tick", int'(remain_bcd), 16'h0059);
    ticks(59);
    chk("t1_alert", int'(alert), 1);
    chk("t1_chime", int'(chime), 1);
    chk("t1_remain", int'(remain_bcd), 16'h0000);
    chk("t1_state", int'(state), 2);
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("t1_chime_once", int'(chime), 0);
    chk("t1_alert_held", int'(alert), 1);

    // ack dismisses and re-arms.
    cyc(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("t2_alert", int'(alert), 0);
    chk("t2_state", int'(state), 1);
    chk("t2_remain", int'(remain_bcd), 16'h0100);
    chk("t2_missed", int'(missed), 0);

    // Pause in ALERT at 00:00, then resume reloads the interval.
    ticks(60);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("idle_state", int'(state), 0);
    chk("idle_remain", int'(remain_bcd), 16'h0000);
    chk("idle_alert", int'(alert), 0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("resume_remain", int'(remain_bcd), 16'h0100);
    chk("resume_state", int'(state), 1);

    // ack on the same clock as the timeout tick: ack wins.
    ticks(60);
    ticks(59);
    cyc(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("t5_ack_vs_timeout", int'(missed), 0);
    chk("t5_state", int'(state), 1);

    // Timeouts increment missed and saturate at 15.
    for (int k = 1; k <= 16; k++) begin
      ticks(60);
      ticks(60);
      if (k == 1) begin
        chk("t3_missed1", int'(missed), 1);
        chk("t3_state", int'(state), 1);
        chk("t3_remain", int'(remain_bcd), 16'h0100);
      end
    end
    chk("t3_saturate", int'(missed), 15);

    // load and tick together: tick ignored.
    cyc(1'b1, 8'h02, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("t5_load_tick", int'(remain_bcd), 16'h0200);
    chk("t5_missed_kept", int'(missed), 15);

    // Pause at 12:34, hold, resume.
    cyc(1'b1, 8'h13, 1'b1, 1'b0, 1'b0, 1'b0);
    ticks(26);
    chk("t4_1234", int'(remain_bcd), 16'h1234);
    for (int i = 0; i < 3; i++) cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("t4_hold", int'(remain_bcd), 16'h1234);
    chk("t4_idle", int'(state), 0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("t4_reenable", int'(remain_bcd), 16'h1234);
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("t4_1233", int'(remain_bcd), 16'h1233);
    cyc(1'b1, 8'h10, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("t4_min_borrow", int'(remain_bcd), 16'h0959);

    // Snooze from ALERT.
    cyc(1'b1, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0);
    ticks(60);
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
`ifdef REMINDER_SNOOZE_EN
    chk("t6_state", int'(state), 3);
    chk("t6_remain", int'(remain_bcd), 16'h0500);
    chk("t6_alert", int'(alert), 0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1);
    chk("t6_resnooze", int'(remain_bcd), 16'h0459);
    ticks(298);
    chk("t6_0001", int'(remain_bcd), 16'h0001);
    ticks(1);
    chk("t6_expire", int'(state), 2);
    chk("t6_chime", int'(chime), 1);
`else
    chk("t6_ignored_state", int'(state), 2);
    chk("t6_ignored_alert", int'(alert), 1);
    chk("t6_ignored_remain", int'(remain_bcd), 16'h0000);
`endif

    // Asynchronous reset mid-run, away from any clock edge.
    cyc(1'b1, 8'h07, 1'b1, 1'b0, 1'b0, 1'b0);
    ticks(5);
    reset = 1'b1;
    #2;
    chk("areset_remain", int'(remain_bcd), 16'h3000);
    chk("areset_state", int'(state), 0);
    chk("areset_missed", int'(missed), 0);
    reset = 1'b0;
    model_reset();

    // Randomized phase against the model.
    en_r = 1'b1;
    for (int i = 0; i < 8000; i++) begin
      logic [7:0] lv;
      bit ld;
      case ($urandom_range(0, 3))
        0:       lv = 8'h01;
        1:       lv = 8'h02;
        default: lv = 8'($urandom);
      endcase
      ld = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 39) == 0) en_r = ~en_r;
      cyc(ld, lv, en_r, $urandom_range(0, 49) == 0, $urandom_range(0, 19) == 0,
          $urandom_range(0, 1) == 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
